// File: rtl/ifetch.sv
// Instruction fetch unit: keeps the fetch PC, prefetches words from instruction
// memory into a 2-entry buffer and hands them to the IR one strobe at a time.
module ifetch #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_fetch,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_data,
  output logic [15:0]   ins,
  output logic          ins_en,
  output logic [AW-1:0] pc,
  output logic          stall
);

  logic [AW-1:0] buf_addr [2];
  logic [15:0]   buf_word [2];
  logic [1:0]    count;
  logic          pending;
  logic          discard;
  logic [AW-1:0] fetch_pc;

  logic          ack;
  logic          push;
  logic          pop;
  logic [1:0]    count_nxt;
  logic [1:0]    wr_slot;
  logic          pending_nxt;
  logic          discard_nxt;
  logic [AW-1:0] fetch_pc_nxt;
  logic          req_nxt;
  logic [AW-1:0] addr_nxt;
  logic          stall_nxt;

  always_comb begin
    ack          = mem_req & mem_ack;
    push         = ack & ~discard & ~jmp;
    pop          = ~jmp & (en_fetch | pending) & (count != 2'd0);
    count_nxt    = count;
    wr_slot      = count;
    pending_nxt  = pending;
    discard_nxt  = discard;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = mem_req;
    addr_nxt     = mem_addr;

    if (jmp) begin
      count_nxt    = 2'd0;
      fetch_pc_nxt = jmp_addr;
      pending_nxt  = pending | en_fetch;
    end else begin
      count_nxt   = count + {1'b0, push} - {1'b0, pop};
      wr_slot     = pop ? count - 2'd1 : count;
      pending_nxt = pop ? 1'b0 : (pending | en_fetch);
      if (push)
        fetch_pc_nxt = fetch_pc + 1'b1;
    end

    if (mem_req & ~mem_ack & jmp)
      discard_nxt = 1'b1;
    else if (ack)
      discard_nxt = 1'b0;

    // An unacked request is held; a discarded ack leaves one idle edge before reissue.
    if (mem_req & ~mem_ack) begin
      req_nxt  = 1'b1;
      addr_nxt = mem_addr;
    end else if (ack & discard & ~jmp) begin
      req_nxt = 1'b0;
    end else if (count_nxt != 2'd2) begin
      req_nxt  = 1'b1;
      addr_nxt = fetch_pc_nxt;
    end else begin
      req_nxt = 1'b0;
    end

    stall_nxt = pending_nxt & (count_nxt == 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_addr[0] <= '0;
      buf_addr[1] <= '0;
      buf_word[0] <= '0;
      buf_word[1] <= '0;
      count       <= 2'd0;
      pending     <= 1'b0;
      discard     <= 1'b0;
      fetch_pc    <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ins         <= '0;
      ins_en      <= 1'b0;
      pc          <= '0;
      stall       <= 1'b0;
    end else begin
      count    <= count_nxt;
      pending  <= pending_nxt;
      discard  <= discard_nxt;
      fetch_pc <= fetch_pc_nxt;
      mem_req  <= req_nxt;
      mem_addr <= addr_nxt;
      stall    <= stall_nxt;
      ins_en   <= pop;
      if (pop) begin
        ins         <= buf_word[0];
        pc          <= buf_addr[0];
        buf_word[0] <= buf_word[1];
        buf_addr[0] <= buf_addr[1];
      end
      // Head is entry 0; a write after the shift lands in the freed slot.
      if (push) begin
        buf_word[wr_slot[0]] <= mem_data;
        buf_addr[wr_slot[0]] <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus randomized traffic, checked by a
// scoreboard that predicts the delivered instruction stream from jumps/fetches.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_fetch = 1'b0;
  logic        jmp = 1'b0;
  logic [7:0]  jmp_addr = 8'h00;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] ins;
  logic        ins_en;
  logic [7:0]  pc;
  logic        stall;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp_next = 8'h10;

  int mem_mode = 0;
  int lat_cnt = 0;
  int lat_target = 0;

  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  ifetch #(.AW(8), .RESET_PC(8'h10)) dut (
    .clk(clk), .rst(rst), .en_fetch(en_fetch), .jmp(jmp), .jmp_addr(jmp_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ins(ins), .ins_en(ins_en), .pc(pc), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ef, input logic j, input logic [7:0] ja);
    en_fetch = ef;
    jmp      = j;
    jmp_addr = ja;
    tick();
    en_fetch = 1'b0;
    jmp      = 1'b0;
  endtask

  task automatic wait_delivery(input logic [7:0] exp, input string name);
    int k = 0;
    while (!ins_en && k < 30) begin
      tick();
      k++;
    end
    if (!ins_en) check_output({name, "_timeout"}, {31'd0, ins_en}, 32'd1);
    else check_output(name, {24'd0, pc}, {24'd0, exp});
  endtask

  task automatic fetch_one(input logic [7:0] exp, input string name);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    wait_delivery(exp, name);
    tick();
  endtask

  // Memory responder: mode 0 acks every cycle, 1 random latency, 2 fixed 3-cycle latency.
  initial forever begin
    @(posedge clk);
    #2;
    if (mem_mode == 0) begin
      mem_ack = 1'b1;
      lat_cnt = 0;
    end else if (!mem_req) begin
      mem_ack = 1'b0;
    end else if (lat_cnt >= lat_target) begin
      mem_ack    = 1'b1;
      lat_cnt    = 0;
      lat_target = (mem_mode == 1) ? int'($urandom_range(0, 3)) : 3;
    end else begin
      mem_ack = 1'b0;
      lat_cnt++;
    end
    mem_data = mem_word(mem_addr);
  end

  // Reference model: the IR sees consecutive addresses, restarting at each jump target.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      exp_next = 8'h10;
    end else begin
      if (en_fetch) begin
        exp_q.push_back(exp_next);
        exp_next++;
      end
      if (jmp) begin
        int n;
        n = exp_q.size();
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(jmp_addr + 8'(i));
        exp_next = jmp_addr + 8'(n);
      end
    end
  end

  // Monitor: handshake stability and in-order delivery against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_req && !prev_ack) begin
        check_output("req_held", {31'd0, mem_req}, 32'd1);
        check_output("addr_held", {24'd0, mem_addr}, {24'd0, prev_addr});
      end
      if (ins_en) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_ins_en", {31'd0, ins_en}, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check_output("deliver_pc", {24'd0, pc}, {24'd0, e});
          check_output("deliver_ins", {16'd0, ins}, {16'd0, mem_word(e)});
        end
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    rst      = 1'b0;
    mem_mode = 0;
    repeat (3) tick();
    check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check_output("rst_ins", {16'd0, ins}, 32'd0);
    check_output("rst_ins_en", {31'd0, ins_en}, 32'd0);
    check_output("rst_pc", {24'd0, pc}, 32'd0);
    check_output("rst_stall", {31'd0, stall}, 32'd0);

    rst = 1'b1;
    tick();
    check_output("fill_req0", {31'd0, mem_req}, 32'd1);
    check_output("fill_addr0", {24'd0, mem_addr}, 32'h10);
    tick();
    check_output("fill_req1", {31'd0, mem_req}, 32'd1);
    check_output("fill_addr1", {24'd0, mem_addr}, 32'h11);
    tick();
    check_output("full_req_low", {31'd0, mem_req}, 32'd0);
    tick();
    check_output("full_req_still_low", {31'd0, mem_req}, 32'd0);

    $display("[TB] pipelined delivery");
    en_fetch = 1'b1;
    tick();
    check_output("pipe_ins_en0", {31'd0, ins_en}, 32'd1);
    check_output("pipe_pc0", {24'd0, pc}, 32'h10);
    check_output("pipe_addr12", {24'd0, mem_addr}, 32'h12);
    tick();
    check_output("pipe_ins_en1", {31'd0, ins_en}, 32'd1);
    check_output("pipe_pc1", {24'd0, pc}, 32'h11);
    check_output("pipe_addr13", {24'd0, mem_addr}, 32'h13);
    en_fetch = 1'b0;
    tick();
    check_output("pipe_ins_en_low", {31'd0, ins_en}, 32'd0);
    check_output("pipe_pc_hold", {24'd0, pc}, 32'h11);

    $display("[TB] slow memory");
    mem_mode   = 2;
    lat_target = 3;
    lat_cnt    = 0;
    en_fetch   = 1'b1;
    tick();
    check_output("slow_pc12", {24'd0, pc}, 32'h12);
    tick();
    check_output("slow_pc13", {24'd0, pc}, 32'h13);
    tick();
    en_fetch = 1'b0;
    check_output("slow_stall_set", {31'd0, stall}, 32'd1);
    check_output("slow_no_ins_en", {31'd0, ins_en}, 32'd0);
    tick();
    check_output("slow_stall_hold", {31'd0, stall}, 32'd1);
    tick();
    check_output("slow_stall_clear", {31'd0, stall}, 32'd0);
    check_output("slow_ins_en_wait", {31'd0, ins_en}, 32'd0);
    tick();
    check_output("slow_ins_en", {31'd0, ins_en}, 32'd1);
    check_output("slow_pc14", {24'd0, pc}, 32'h14);

    $display("[TB] jump during outstanding request");
    apply_stimulus(1'b0, 1'b1, 8'h40);
    check_output("jmp_req_held", {31'd0, mem_req}, 32'd1);
    check_output("jmp_addr_held", {24'd0, mem_addr}, 32'h15);
    tick();
    check_output("jmp_addr_held2", {24'd0, mem_addr}, 32'h15);
    tick();
    check_output("jmp_discard_idle", {31'd0, mem_req}, 32'd0);
    tick();
    check_output("jmp_new_req", {31'd0, mem_req}, 32'd1);
    check_output("jmp_new_addr", {24'd0, mem_addr}, 32'h40);
    mem_mode = 0;
    fetch_one(8'h40, "jmp_pc40");

    $display("[TB] simultaneous jmp, ack and fetch");
    repeat (4) tick();
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("sim_pre_req", {31'd0, mem_req}, 32'd1);
    apply_stimulus(1'b1, 1'b1, 8'h80);
    check_output("sim_req", {31'd0, mem_req}, 32'd1);
    check_output("sim_addr", {24'd0, mem_addr}, 32'h80);
    check_output("sim_ins_en0", {31'd0, ins_en}, 32'd0);
    tick();
    check_output("sim_ins_en1", {31'd0, ins_en}, 32'd0);
    tick();
    check_output("sim_ins_en2", {31'd0, ins_en}, 32'd1);
    check_output("sim_pc80", {24'd0, pc}, 32'h80);

    $display("[TB] address wrap");
    repeat (4) tick();
    apply_stimulus(1'b0, 1'b1, 8'hFE);
    repeat (2) tick();
    fetch_one(8'hFE, "wrap_pcFE");
    fetch_one(8'hFF, "wrap_pcFF");
    fetch_one(8'h00, "wrap_pc00");

    $display("[TB] randomized traffic");
    mem_mode   = 1;
    lat_cnt    = 0;
    lat_target = int'($urandom_range(0, 3));
    for (int i = 0; i < 3000; i++) begin
      en_fetch = (exp_q.size() == 0) && ($urandom_range(0, 2) == 0);
      jmp      = ($urandom_range(0, 24) == 0);
      jmp_addr = 8'($urandom);
      tick();
    end
    en_fetch = 1'b0;
    jmp      = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check_output("random_drain", exp_q.size(), 32'd0);

    $display("[TB] asynchronous reset mid-operation");
    mem_mode = 0;
    repeat (2) tick();
    en_fetch = 1'b1;
    tick();
    en_fetch = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("arst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check_output("arst_ins", {16'd0, ins}, 32'd0);
    check_output("arst_ins_en", {31'd0, ins_en}, 32'd0);
    check_output("arst_pc", {24'd0, pc}, 32'd0);
    check_output("arst_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_output("arst_restart_req", {31'd0, mem_req}, 32'd1);
    check_output("arst_restart_addr", {24'd0, mem_addr}, 32'h10);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
